// File: rtl/data_selector_rr.sv
// Selects one of CHANNELS valid/ready input channels into a one-entry output register.
// The channel comes from i_sel (MODE=0) or from a round-robin search starting at r_ptr (MODE=1).
module data_selector_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int SW      = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS*WIDTH-1:0] i_in_data,
    input  logic [CHANNELS-1:0]       i_in_valid,
    output logic [CHANNELS-1:0]       o_in_ready,
    input  logic [SW-1:0]             i_sel,
    output logic [WIDTH-1:0]          o_out_data,
    output logic [SW-1:0]             o_out_ch,
    output logic                      o_out_valid,
    input  logic                      i_out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_ch;
    logic             r_out_valid;
    logic [SW-1:0]    r_ptr;

    logic [SW:0]      w_sum      [CHANNELS];
    logic [SW-1:0]    w_idx      [CHANNELS];
    logic [CHANNELS-1:0] w_rot_valid;
    logic [SW-1:0]    w_rr_cand;
    logic             w_rr_req;
    logic             w_sel_req;
    logic [SW-1:0]    w_cand;
    logic             w_req;
    logic             w_space;
    logic             w_accept;
    logic [WIDTH-1:0] w_cand_data;
    logic [SW-1:0]    w_ptr_next;

    // Offset gi from the pointer, folded back into 0..CHANNELS-1 without a divider.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_rot
            assign w_sum[gi]       = {1'b0, r_ptr} + (SW+1)'(gi);
            assign w_idx[gi]       = (w_sum[gi] >= (SW+1)'(CHANNELS))
                                     ? SW'(w_sum[gi] - (SW+1)'(CHANNELS))
                                     : w_sum[gi][SW-1:0];
            assign w_rot_valid[gi] = i_in_valid[w_idx[gi]];
        end
    endgenerate

    // Walking offsets downward leaves the nearest valid channel as the winner.
    always_comb begin
        w_rr_cand = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_rot_valid[i]) begin
                w_rr_cand = w_idx[i];
            end
        end
    end

    assign w_rr_req = |i_in_valid;

    always_comb begin
        w_sel_req = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_sel == SW'(k)) begin
                w_sel_req = i_in_valid[k];
            end
        end
    end

    assign w_cand   = (MODE == 1) ? w_rr_cand : i_sel;
    assign w_req    = (MODE == 1) ? w_rr_req  : w_sel_req;
    assign w_space  = !r_out_valid || i_out_ready;
    assign w_accept = w_space && w_req && !i_rst;

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign o_in_ready[gi] = w_accept && (w_cand == SW'(gi));
        end
    endgenerate

    always_comb begin
        w_cand_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_cand == SW'(k)) begin
                w_cand_data = i_in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_cand == SW'(CHANNELS - 1)) ? '0 : w_cand + SW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_accept) begin
            r_out_data  <= w_cand_data;
            r_out_ch    <= w_cand;
            r_out_valid <= 1'b1;
            if (MODE == 1) begin
                r_ptr <= w_ptr_next;
            end
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_data_selector_rr.sv
// Directed bench for data_selector_rr: fixed select, round-robin, 3-channel/8-bit
// variant, stall behaviour and asynchronous reset while holding a word.
module tb_data_selector_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // MODE=0, 4 channels x 4 bits
    logic [15:0] d0_data;
    logic [3:0]  d0_valid;
    logic [3:0]  d0_ready;
    logic [1:0]  d0_sel;
    logic [3:0]  d0_odata;
    logic [1:0]  d0_och;
    logic        d0_ovalid;
    logic        d0_oready;

    // MODE=1, 4 channels x 4 bits
    logic [15:0] d1_data;
    logic [3:0]  d1_valid;
    logic [3:0]  d1_ready;
    logic [1:0]  d1_sel;
    logic [3:0]  d1_odata;
    logic [1:0]  d1_och;
    logic        d1_ovalid;
    logic        d1_oready;

    // MODE=1, 3 channels x 8 bits
    logic [23:0] d2_data;
    logic [2:0]  d2_valid;
    logic [2:0]  d2_ready;
    logic [1:0]  d2_sel;
    logic [7:0]  d2_odata;
    logic [1:0]  d2_och;
    logic        d2_ovalid;
    logic        d2_oready;

    data_selector_rr #(.WIDTH(4), .CHANNELS(4), .MODE(0)) u_dut_sel (
        .i_clk(clk), .i_rst(rst),
        .i_in_data(d0_data), .i_in_valid(d0_valid), .o_in_ready(d0_ready),
        .i_sel(d0_sel),
        .o_out_data(d0_odata), .o_out_ch(d0_och), .o_out_valid(d0_ovalid),
        .i_out_ready(d0_oready)
    );

    data_selector_rr #(.WIDTH(4), .CHANNELS(4), .MODE(1)) u_dut_rr (
        .i_clk(clk), .i_rst(rst),
        .i_in_data(d1_data), .i_in_valid(d1_valid), .o_in_ready(d1_ready),
        .i_sel(d1_sel),
        .o_out_data(d1_odata), .o_out_ch(d1_och), .o_out_valid(d1_ovalid),
        .i_out_ready(d1_oready)
    );

    data_selector_rr #(.WIDTH(8), .CHANNELS(3), .MODE(1)) u_dut_rr3 (
        .i_clk(clk), .i_rst(rst),
        .i_in_data(d2_data), .i_in_valid(d2_valid), .o_in_ready(d2_ready),
        .i_sel(d2_sel),
        .o_out_data(d2_odata), .o_out_ch(d2_och), .o_out_valid(d2_ovalid),
        .i_out_ready(d2_oready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        d0_data = 16'h3A17; d0_valid = 4'hF; d0_sel = 2'd0; d0_oready = 1'b1;
        d1_data = 16'hDCBA; d1_valid = 4'hF; d1_sel = 2'd0; d1_oready = 1'b1;
        d2_data = {8'hF0, 8'h5A, 8'hA5}; d2_valid = 3'b111; d2_sel = 2'd0; d2_oready = 1'b1;

        // Reset with every channel requesting
        tick(); tick();
        chk("rst_in_ready_sel", 32'(d0_ready), 32'h0);
        chk("rst_in_ready_rr", 32'(d1_ready), 32'h0);
        chk("rst_out_valid", 32'(d0_ovalid), 32'h0);
        chk("rst_out_data", 32'(d0_odata), 32'h0);
        chk("rst_out_ch", 32'(d0_och), 32'h0);

        rst = 1'b0;
        d1_valid = 4'h0;
        d2_valid = 3'b000;
        #1;
        chk("rel_in_ready", 32'(d0_ready), 32'h1);
        tick();
        chk("rel_first_valid", 32'(d0_ovalid), 32'h1);
        chk("rel_first_data", 32'(d0_odata), 32'h7);

        // Fixed select of channel 2
        d0_sel = 2'd2; d0_valid = 4'b0100; #1;
        chk("sel2_in_ready", 32'(d0_ready), 32'h4);
        tick();
        chk("sel2_data", 32'(d0_odata), 32'hA);
        chk("sel2_ch", 32'(d0_och), 32'h2);
        chk("sel2_valid", 32'(d0_ovalid), 32'h1);
        d0_sel = 2'd3; #1;
        chk("sel3_noreq_ready", 32'(d0_ready), 32'h0);
        tick();
        chk("sel3_drain_valid", 32'(d0_ovalid), 32'h0);
        chk("sel3_hold_data", 32'(d0_odata), 32'hA);

        // Stall with 5 held, then refill without a bubble
        d0_data = 16'h3A50; d0_sel = 2'd1; d0_valid = 4'b0010;
        tick();
        chk("stall_load_data", 32'(d0_odata), 32'h5);
        d0_oready = 1'b0; d0_sel = 2'd2; d0_valid = 4'b0110; #1;
        chk("stall_in_ready", 32'(d0_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_data", i), 32'(d0_odata), 32'h5);
            chk($sformatf("stall%0d_ch", i), 32'(d0_och), 32'h1);
            chk($sformatf("stall%0d_valid", i), 32'(d0_ovalid), 32'h1);
            chk($sformatf("stall%0d_ready", i), 32'(d0_ready), 32'h0);
        end
        d0_oready = 1'b1; #1;
        chk("unstall_in_ready", 32'(d0_ready), 32'h4);
        tick();
        chk("unstall_data", 32'(d0_odata), 32'hA);
        chk("unstall_ch", 32'(d0_och), 32'h2);
        chk("unstall_valid", 32'(d0_ovalid), 32'h1);
        d0_valid = 4'h0;
        tick();
        chk("sel_idle_valid", 32'(d0_ovalid), 32'h0);

        // Round-robin over four always-valid channels
        d1_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr%0d_ch", i), 32'(d1_och), 32'(i % 4));
            chk($sformatf("rr%0d_data", i), 32'(d1_odata), 32'(4'hA + (i % 4)));
            chk($sformatf("rr%0d_valid", i), 32'(d1_ovalid), 32'h1);
        end
        // Pointer now 1: channels 0 and 3 requesting
        d1_valid = 4'b1001; #1;
        chk("rr_1001_ready", 32'(d1_ready), 32'h8);
        tick();
        chk("rr_1001_first", 32'(d1_och), 32'h3);
        tick();
        chk("rr_1001_second", 32'(d1_och), 32'h0);
        d1_valid = 4'h0;
        tick();
        chk("rr_idle_valid", 32'(d1_ovalid), 32'h0);

        // Async reset while holding a stalled word (pointer is 1 here)
        d1_valid = 4'hF;
        tick();
        chk("rr_pre_rst_ch", 32'(d1_och), 32'h1);
        d1_oready = 1'b0;
        tick();
        chk("rr_stall_ch", 32'(d1_och), 32'h1);
        chk("rr_stall_valid", 32'(d1_ovalid), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(d1_ovalid), 32'h0);
        chk("async_rst_ready", 32'(d1_ready), 32'h0);
        tick();
        rst = 1'b0; d1_oready = 1'b1; #1;
        chk("post_rst_ready", 32'(d1_ready), 32'h1);
        tick();
        chk("post_rst_ch", 32'(d1_och), 32'h0);
        chk("post_rst_data", 32'(d1_odata), 32'hA);
        d1_valid = 4'h0;

        // Three channels, 8-bit data, wrap after channel 2
        d2_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr3_%0d_ch", i), 32'(d2_och), 32'(i % 3));
            case (i % 3)
                0: chk($sformatf("rr3_%0d_data", i), 32'(d2_odata), 32'hA5);
                1: chk($sformatf("rr3_%0d_data", i), 32'(d2_odata), 32'h5A);
                default: chk($sformatf("rr3_%0d_data", i), 32'(d2_odata), 32'hF0);
            endcase
        end
        d2_valid = 3'b000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
